seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor and the sequential successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through an internal carry register.
- Uses a start/busy/done handshake.
- Intended for area-constrained datapaths where a full-width combinational adder is too large.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- Derived constant NCH = WIDTH/CHUNK: cycles per operation.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin. 1: a-b, computed as a+~b+1 (cin ignored).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; holds until the next completion.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal carry, chunk counter and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, ~b-or-b per sub, and carry seed (sub ? 1 : cin); counter=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=0: remain in IDLE.
- RUN, every edge:
  - compute chunk[counter] = a_chunk + b_chunk + carry, CHUNK+1 bits wide;
  - store the low CHUNK bits into the result register at bit offset counter*CHUNK;
  - carry <= MSB of that sum; counter++.
  - When counter == NCH-1: also capture the carry into bit WIDTH-1 for ovf, then go to DONE.
- DONE (exactly one cycle): done=1, busy=0; sum, cout, ovf registers updated on entry to DONE.
- DONE, start=1: accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: if start is accepted on edge E0, done is high in the cycle following edge E0+NCH. busy is high for exactly NCH cycles.
  - For NCH=1: one RUN cycle, then DONE.
- start while busy=1: ignored; the latched operands are unaffected; no queueing.
- Operand inputs only need to be stable at the accepting edge.
- sum/cout/ovf change only on entry to DONE. Intermediate partial results are never visible.
- rst asserted mid-operation: operation aborted; no done pulse; outputs return to 0. The first start after rst deasserts is accepted normally.
- Width rule: all arithmetic is modulo 2^WIDTH; the carry out of bit WIDTH-1 goes only to cout.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_ACC_EN.
- Defined: extra input port acc (1 bit).
  - When start is accepted with acc=1, operand A is taken from the current sum register instead of port a.
  - b, sub and cin behave as normal.
  - Gives running accumulate/decrement without external feedback.
  - acc is ignored when start is not accepted.
- Undefined: no acc port; operand A always comes from port a.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x1234, b=0x1111, cin=0, sub=0, start pulse -> busy high 4 cycles; single done pulse; sum=0x2345, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 chunks). Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- start with a=0x0001, b=0x0001; re-pulse start with a=0xAAAA during busy -> ignored, sum=0x0002. Start again, assert rst after 2 cycles -> no done, all outputs 0. Next start a=3, b=4 -> sum=0x0007.
- start held high continuously with new operands presented at each DONE cycle -> each operation completes in 5 cycles with exactly one done per result. Repeat with CHUNK=1 (16-cycle busy) and CHUNK=16 (1-cycle busy).
- With SEQ_CHUNK_ADDER_ACC_EN: start a=0x0010, b=0x0005, acc=0 -> sum=0x0015; then acc=1, b=0x0005 -> sum=0x001A; then acc=1, sub=1, b=0x001A -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry rippled through r_carry.
// Optional SEQ_CHUNK_ADDER_ACC_EN adds an acc port that takes operand A from the sum register.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef SEQ_CHUNK_ADDER_ACC_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_res, w_a_src;
  logic [CHUNK:0]   w_ch;
  logic             w_accept, w_last, w_c_msb;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(NCH - 1));

`ifdef SEQ_CHUNK_ADDER_ACC_EN
  assign w_a_src = acc ? r_sum : a;
`else
  assign w_a_src = a;
`endif

  // One chunk slice per cycle; r_res collects the partial result out of sight of sum.
  always_comb begin
    w_res = r_res;
    w_ch  = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]} + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, r_carry};
    w_res[r_cnt*CHUNK +: CHUNK] = w_ch[CHUNK-1:0];
  end

  // Carry into the MSB recovered from the MSB's own sum bit.
  assign w_c_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_ch[CHUNK-1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_RUN : S_IDLE;
      S_RUN:          if (w_last) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= w_a_src;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= w_res;
      r_carry <= w_ch[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_res;
        r_cout <= w_ch[CHUNK];
        r_ovf  <= w_ch[CHUNK] ^ w_c_msb;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK 4, 1, 16) share stimulus;
// a cycle model predicts acceptance/done timing and a per-instance scoreboard holds results.
module tb_seq_chunk_adder;
  localparam int W  = 16;
  localparam int NI = 3;
`ifdef SEQ_CHUNK_ADDER_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         lv;
    logic [W-1:0] lsum;
    logic         lcout;
    logic         lovf;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0, acc = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [NI-1:0] busy_v, done_v, cout_v, ovf_v;
  logic [NI-1:0][W-1:0] sum_v;
  logic lit_v = 1'b0, lit_cout = 1'b0, lit_ovf = 1'b0;
  logic [W-1:0] lit_sum = '0;
  logic end_req = 1'b0, end_ack = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic int chunk_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
`ifdef SEQ_CHUNK_ADDER_ACC_EN
      .acc   (acc),
`endif
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .sum   (sum_v[g]),
      .cout  (cout_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  function automatic exp_t calc(input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input logic ec, input logic es);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0] t;
    bb = es ? ~eb : eb;
    t  = {1'b0, ea} + {1'b0, bb} + {{W{1'b0}}, (es ? 1'b1 : ec)};
    e = '0;
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (ea[W-1] == bb[W-1]) && (t[W-1] != ea[W-1]);
    return e;
  endfunction

  // Reference model: availability counter, registered result, expected-result queue.
  exp_t q[NI][$];
  int   m_cnt[NI];
  logic m_done[NI];
  logic [W-1:0] m_sum[NI];
  logic m_cout[NI], m_ovf[NI];
  exp_t m_e;

  initial for (int k = 0; k < NI; k++) begin
    m_cnt[k] = 0; m_done[k] = 1'b0; m_sum[k] = '0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_done[k] = 1'b0; m_sum[k] = '0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
        q[k].delete();
      end else begin
        m_done[k] = 1'b0;
        if (m_cnt[k] == 0) begin
          if (start) begin
            m_e = calc((ACC_EN && acc) ? m_sum[k] : a, b, cin, sub);
            m_e.lv = lit_v; m_e.lsum = lit_sum; m_e.lcout = lit_cout; m_e.lovf = lit_ovf;
            q[k].push_back(m_e);
            m_cnt[k] = W / chunk_of(k);
          end
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_done[k] = 1'b1;
            m_sum[k] = q[k][0].sum; m_cout[k] = q[k][0].cout; m_ovf[k] = q[k][0].ovf;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  exp_t p;
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("busy[%0d]", k), 32'(busy_v[k]), 32'(m_cnt[k] != 0));
      chk($sformatf("done[%0d]", k), 32'(done_v[k]), 32'(m_done[k]));
      if (done_v[k]) begin
        if (q[k].size() == 0) chk($sformatf("sb_underflow[%0d]", k), 32'd1, 32'd0);
        else begin
          p = q[k].pop_front();
          chk($sformatf("sum[%0d]", k),  32'(sum_v[k]),  32'(p.sum));
          chk($sformatf("cout[%0d]", k), 32'(cout_v[k]), 32'(p.cout));
          chk($sformatf("ovf[%0d]", k),  32'(ovf_v[k]),  32'(p.ovf));
          if (p.lv) begin
            chk($sformatf("lit_sum[%0d]", k),  32'(sum_v[k]),  32'(p.lsum));
            chk($sformatf("lit_cout[%0d]", k), 32'(cout_v[k]), 32'(p.lcout));
            chk($sformatf("lit_ovf[%0d]", k),  32'(ovf_v[k]),  32'(p.lovf));
          end
        end
      end else begin
        chk($sformatf("hold_sum[%0d]", k),  32'(sum_v[k]),  32'(m_sum[k]));
        chk($sformatf("hold_cout[%0d]", k), 32'(cout_v[k]), 32'(m_cout[k]));
        chk($sformatf("hold_ovf[%0d]", k),  32'(ovf_v[k]),  32'(m_ovf[k]));
      end
    end
    if (end_req && !end_ack) begin
      for (int k = 0; k < NI; k++) chk($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'd0);
      end_ack <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                    input logic is, input logic iacc, input logic [W-1:0] ls,
                    input logic lc, input logic lo);
    a = ia; b = ib; cin = ic; sub = is; acc = iacc; start = 1'b1;
    lit_v = 1'b1; lit_sum = ls; lit_cout = lc; lit_ovf = lo;
    step();
    start = 1'b0; lit_v = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom); acc = 1'b0;
    repeat (18) step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op(16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    // Second start pulse lands while busy and must not disturb the latched operands.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    lit_v = 1'b1; lit_sum = 16'h0002; lit_cout = 1'b0; lit_ovf = 1'b0;
    step();
    a = 16'hAAAA; lit_v = 1'b0;
    step();
    start = 1'b0;
    repeat (18) step();
    // Abort mid-operation, then a clean operation afterwards.
    a = 16'h0009; b = 16'h0009; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    // start held high with fresh random operands every cycle: back-to-back streams.
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      acc = ACC_EN ? 1'($urandom) : 1'b0;
      step();
    end
    start = 1'b0; acc = 1'b0;
    repeat (20) step();
`ifdef SEQ_CHUNK_ADDER_ACC_EN
    op(16'h0010, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b0);
    op(16'hDEAD, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h001A, 1'b0, 1'b0);
    op(16'hBEEF, 16'h001A, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
`endif
    end_req = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
